// File: rtl/tetris_pkg.sv
// Shared board geometry, cell/row types and the row-fetch state encoding.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int COL_W   = $clog2(BOARD_W);

    typedef logic [CELL_W-1:0] cell_t;
    typedef cell_t [BOARD_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } fetch_state_t;

    // First RAM address of a board row; the product always fits ADDR_W.
    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] r);
        row_base = ADDR_W'(32'(r) * BOARD_W);
    endfunction

endpackage

// File: rtl/board_row_fetcher_piece_cell_match.sv
// 4-way piece coordinate compare: hit when any piece cell sits at (col_i, row_i).
// Only built with PIECE_OVERLAY_EN defined.
`ifdef PIECE_OVERLAY_EN
module piece_cell_match
    import tetris_pkg::*;
(
    input  logic [3:0][3:0]   piece_x_i,
    input  logic [3:0][4:0]   piece_y_i,
    input  logic [7:0]        row_i,
    input  logic [COL_W-1:0]  col_i,
    output logic              hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ({3'b000, piece_y_i[i]} == row_i && piece_x_i[i] == col_i) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/board_row_fetcher.sv
// Fetches one board row from RAM into a shadow buffer and commits it atomically to Row.
// Optional falling-piece overlay on captured cells: define PIECE_OVERLAY_EN.
module board_row_fetcher
    import tetris_pkg::*;
(
    input  logic               Clk,
    input  logic               reset,
`ifdef PIECE_OVERLAY_EN
    input  logic               piece_valid,
    input  logic [3:0][3:0]    piece_x,
    input  logic [3:0][4:0]    piece_y,
    input  cell_t              piece_color,
`endif
    input  logic               LD_Row,
    input  logic [7:0]         rowNum,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_rd,
    input  cell_t              ram_data,
    output row_t               Row,
    output logic               rowReady,
    output logic               busy,
    output logic               err_oob,
    output fetch_state_t       dbg_state
);

    fetch_state_t       state_q;
    logic               ld_row_q;
    logic [7:0]         row_q;
    logic [ADDR_W-1:0]  base_q;
    logic [COL_W-1:0]   col_q;
    logic               pend_valid_q;
    logic [7:0]         pend_row_q;
    logic               cap_valid_q;
    logic [COL_W-1:0]   cap_col_q;
    row_t               shadow_q;
    row_t               row_out_q;
    logic               ready_q;
    logic               err_q;
    logic               busy_q;
    logic               rd_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               req;
    logic               oob;
    logic               start;
    logic [7:0]         start_row;
    cell_t              cap_cell;

    assign req = LD_Row & ~ld_row_q;
    assign oob = (row_q >= 8'(BOARD_H));

    // A fetch starts from IDLE, or back-to-back on the commit edge when a request is waiting.
    always_comb begin
        start     = 1'b0;
        start_row = rowNum;
        case (state_q)
            IDLE:   start = req;
            COMMIT: begin
                start     = req | pend_valid_q;
                start_row = req ? rowNum : pend_row_q;
            end
            default: ;
        endcase
    end

`ifdef PIECE_OVERLAY_EN
    logic             pv_q;
    logic [3:0][3:0]  px_q;
    logic [3:0][4:0]  py_q;
    cell_t            pc_q;
    logic             hit;

    piece_cell_match u_match (
        .piece_x_i (px_q),
        .piece_y_i (py_q),
        .row_i     (row_q),
        .col_i     (cap_col_q),
        .hit_o     (hit)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            pv_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
            pc_q <= '0;
        end else if (start) begin
            pv_q <= piece_valid;
            px_q <= piece_x;
            py_q <= piece_y;
            pc_q <= piece_color;
        end
    end

    assign cap_cell = (pv_q && hit) ? pc_q : ram_data;
`else
    assign cap_cell = ram_data;
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ld_row_q     <= 1'b0;
            row_q        <= '0;
            base_q       <= '0;
            col_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_row_q   <= '0;
            cap_valid_q  <= 1'b0;
            cap_col_q    <= '0;
            shadow_q     <= '0;
            row_out_q    <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
        end else begin
            ld_row_q    <= LD_Row;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            cap_valid_q <= 1'b0;

            // Read data for the column issued last cycle is on ram_data now.
            if (cap_valid_q) begin
                shadow_q[cap_col_q] <= cap_cell;
            end

            if (start) begin
                row_q   <= start_row;
                base_q  <= row_base(start_row);
                col_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= FETCH;
                if (start_row < 8'(BOARD_H)) begin
                    rd_q   <= 1'b1;
                    addr_q <= row_base(start_row);
                end
            end

            if (req && (state_q == FETCH || state_q == DRAIN)) begin
                pend_valid_q <= 1'b1;
                pend_row_q   <= rowNum;
            end

            case (state_q)
                FETCH: begin
                    cap_valid_q <= ~oob;
                    cap_col_q   <= col_q;
                    if (col_q == COL_W'(BOARD_W - 1)) begin
                        rd_q    <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        col_q <= col_q + 1'b1;
                        if (!oob) begin
                            addr_q <= base_q + ADDR_W'(col_q) + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: state_q <= COMMIT;
                COMMIT: begin
                    row_out_q    <= oob ? '0 : shadow_q;
                    ready_q      <= 1'b1;
                    err_q        <= oob;
                    pend_valid_q <= 1'b0;
                    if (!start) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = addr_q;
    assign ram_rd    = rd_q;
    assign Row       = row_out_q;
    assign rowReady  = ready_q;
    assign busy      = busy_q;
    assign err_oob   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_board_row_fetcher.sv
// Self-checking bench for board_row_fetcher: timestamp-based request model plus directed literal checks.
// Overlay scenario and random piece stimulus are included when PIECE_OVERLAY_EN is defined.
module tb_board_row_fetcher;
    import tetris_pkg::*;

    logic               Clk = 1'b0;
    logic               reset = 1'b1;
    logic               LD_Row = 1'b0;
    logic [7:0]         rowNum = '0;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_rd;
    cell_t              ram_data = '0;
    row_t               Row;
    logic               rowReady;
    logic               busy;
    logic               err_oob;
    fetch_state_t       dbg_state;

    logic               piece_valid = 1'b0;
    logic [3:0][3:0]    piece_x = '0;
    logic [3:0][4:0]    piece_y = '0;
    cell_t              piece_color = '0;

    always #5 Clk = ~Clk;

    board_row_fetcher dut (
        .Clk         (Clk),
        .reset       (reset),
`ifdef PIECE_OVERLAY_EN
        .piece_valid (piece_valid),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .piece_color (piece_color),
`endif
        .LD_Row      (LD_Row),
        .rowNum      (rowNum),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_data    (ram_data),
        .Row         (Row),
        .rowReady    (rowReady),
        .busy        (busy),
        .err_oob     (err_oob),
        .dbg_state   (dbg_state)
    );

    // Board RAM: cell(r,c) = 16'h0100*r + c, read data valid the cycle after ram_rd.
    always @(posedge Clk) begin
        if (ram_rd) ram_data <= cell_t'(256 * (int'(ram_addr) / 10) + int'(ram_addr) % 10);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic row_t model_row(input int r, input bit pv, input logic [3:0][3:0] px,
                                       input logic [3:0][4:0] py, input cell_t pc);
        row_t res;
        for (int c = 0; c < BOARD_W; c++) begin
            res[c] = cell_t'(256 * r + c);
            if (pv) for (int i = 0; i < 4; i++)
                if (int'(py[i]) == r && int'(px[i]) == c) res[c] = pc;
        end
        return res;
    endfunction

    // Reference model: an accepted request at edge t0 reads at t0..t0+9 and commits at t0+12.
    int    cyc = 0;
    bit    m_init = 0, m_busy = 0, m_pend = 0, m_ld_prev = 0, m_ready = 0, m_err = 0, exp_rd = 0;
    int    m_t0 = 0, m_row = 0, m_pend_row = 0;
    bit    m_pv = 0;
    logic [3:0][3:0] m_px = '0;
    logic [3:0][4:0] m_py = '0;
    cell_t m_pc = '0;
    row_t  exp_row = '0;
    logic [ADDR_W-1:0] exp_addr = '0;

    initial forever begin
        bit req, acc;
        int arow;
        @(posedge Clk);
        cyc++;
        m_ready = 0;
        m_err = 0;
        acc = 0;
        arow = 0;
        if (reset) begin
            m_init = 1; m_busy = 0; m_pend = 0; m_ld_prev = 0;
            exp_row = '0; exp_addr = '0; exp_rd = 0;
        end else begin
            req = LD_Row && !m_ld_prev;
            if (m_busy && cyc == m_t0 + 12) begin
                m_ready = 1;
                m_err = (m_row >= BOARD_H);
                exp_row = m_err ? '0 : model_row(m_row, m_pv, m_px, m_py, m_pc);
                m_busy = 0;
                if (req) begin acc = 1; arow = int'(rowNum); end
                else if (m_pend) begin acc = 1; arow = m_pend_row; end
                m_pend = 0;
            end else if (!m_busy && req) begin
                acc = 1; arow = int'(rowNum);
            end else if (m_busy && req) begin
                m_pend = 1; m_pend_row = int'(rowNum);
            end
            if (acc) begin
                m_busy = 1; m_t0 = cyc; m_row = arow;
                m_pv = piece_valid; m_px = piece_x; m_py = piece_y; m_pc = piece_color;
            end
            m_ld_prev = LD_Row;
            exp_rd = m_busy && m_row < BOARD_H && (cyc - m_t0) <= 9;
            if (exp_rd) exp_addr = ADDR_W'(m_row * BOARD_W + (cyc - m_t0));
        end
    end

    int rd_count = 0, ready_count = 0;
    bit saw_row4 = 0;

    initial forever begin
        @(negedge Clk);
        if (ram_rd) rd_count++;
        if (rowReady) ready_count++;
        if (ram_rd && ram_addr >= 8'd40 && ram_addr <= 8'd49) saw_row4 = 1;
        if (m_init) begin
            chk("ram_rd", 160'(ram_rd), 160'(exp_rd));
            chk("ram_addr", 160'(ram_addr), 160'(exp_addr));
            chk("busy", 160'(busy), 160'(m_busy));
            chk("rowReady", 160'(rowReady), 160'(m_ready));
            chk("err_oob", 160'(err_oob), 160'(m_err));
            chk("Row", 160'(Row), 160'(exp_row));
            if (!m_busy) chk("state_idle", 160'(dbg_state), 160'(IDLE));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse(input int r);
        rowNum = 8'(r);
        LD_Row = 1'b1;
        @(negedge Clk);
        LD_Row = 1'b0;
    endtask

    task automatic wait_ready(input int t0, output int lat);
        int n = 0;
        while (!rowReady && n < 30) begin
            @(negedge Clk);
            n++;
        end
        if (!rowReady) chk("ready_timeout", 160'(0), 160'(1));
        lat = cyc - t0;
    endtask

    initial begin
        int t0, lat, rc;
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat, rc, rd0;
        tick(2);
        chk("row_in_reset", 160'(Row), 160'(0));
        tick(1);
        reset = 1'b0;
        tick(2);

        // 1: basic fetch of row 3
        pulse(3);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            chk("t1_rd", 160'(ram_rd), 160'(1));
            chk("t1_addr", 160'(ram_addr), 160'(30 + k));
            tick(1);
        end
        wait_ready(t0, lat);
        chk("t1_latency", 160'(lat), 160'(12));
        chk("t1_row0", 160'(Row[0]), 160'(16'h0300));
        chk("t1_row9", 160'(Row[9]), 160'(16'h0309));
        tick(3);

        // 2: held LD_Row gives one fetch
        rd0 = rd_count;
        rc = ready_count;
        rowNum = 8'd7;
        LD_Row = 1'b1;
        tick(200);
        LD_Row = 1'b0;
        chk("t2_rd_cycles", 160'(rd_count - rd0), 160'(10));
        chk("t2_ready_count", 160'(ready_count - rc), 160'(1));
        chk("t2_row9", 160'(Row[9]), 160'(16'h0709));
        tick(2);

        // 3: out-of-range row then row 0
        rd0 = rd_count;
        pulse(20);
        t0 = cyc;
        wait_ready(t0, lat);
        chk("t3_latency", 160'(lat), 160'(12));
        chk("t3_err", 160'(err_oob), 160'(1));
        chk("t3_row", 160'(Row), 160'(0));
        chk("t3_no_reads", 160'(rd_count - rd0), 160'(0));
        tick(2);
        pulse(0);
        for (int k = 0; k < 10; k++) begin
            chk("t3_addr", 160'(ram_addr), 160'(k));
            tick(1);
        end
        tick(5);

        // 4: pending latest-wins
        saw_row4 = 0;
        pulse(2);
        t0 = cyc;
        tick(2);
        pulse(4);
        tick(1);
        pulse(5);
        wait_ready(t0, lat);
        chk("t4_latency", 160'(lat), 160'(12));
        chk("t4_row2", 160'(Row[1]), 160'(16'h0201));
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            chk("t4_addr", 160'(ram_addr), 160'(50 + k));
            chk("t4_rd", 160'(ram_rd), 160'(1));
            tick(1);
        end
        wait_ready(t0, lat);
        chk("t4_latency2", 160'(lat), 160'(12));
        chk("t4_row5", 160'(Row[9]), 160'(16'h0509));
        chk("t4_no_row4", 160'(saw_row4), 160'(0));
        tick(3);

        // 5: reset mid-fetch
        pulse(6);
        tick(4);
        reset = 1'b1;
        tick(1);
        chk("t5_rd", 160'(ram_rd), 160'(0));
        chk("t5_busy", 160'(busy), 160'(0));
        chk("t5_row", 160'(Row), 160'(0));
        reset = 1'b0;
        rc = ready_count;
        tick(20);
        chk("t5_no_ready", 160'(ready_count - rc), 160'(0));

`ifdef PIECE_OVERLAY_EN
        // 6: piece overlay on row 3
        piece_valid = 1'b1;
        piece_x[0] = 4'd4; piece_y[0] = 5'd3;
        piece_x[1] = 4'd5; piece_y[1] = 5'd3;
        piece_x[2] = 4'd5; piece_y[2] = 5'd4;
        piece_x[3] = 4'd6; piece_y[3] = 5'd3;
        piece_color = 16'h0F00;
        pulse(3);
        t0 = cyc;
        wait_ready(t0, lat);
        chk("t6_row4", 160'(Row[4]), 160'(16'h0F00));
        chk("t6_row5", 160'(Row[5]), 160'(16'h0F00));
        chk("t6_row6", 160'(Row[6]), 160'(16'h0F00));
        chk("t6_row3", 160'(Row[3]), 160'(16'h0303));
        chk("t6_row7", 160'(Row[7]), 160'(16'h0307));
        piece_valid = 1'b0;
        tick(3);
`endif

        // Random phase
        for (int n = 0; n < 2000; n++) begin
            LD_Row = ($urandom_range(0, 99) < 30);
            rowNum = 8'($urandom_range(0, 23));
            reset = ($urandom_range(0, 299) == 0);
`ifdef PIECE_OVERLAY_EN
            piece_valid = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 4; i++) begin
                piece_x[i] = 4'($urandom_range(0, 9));
                piece_y[i] = 5'($urandom_range(0, 19));
            end
            piece_color = 16'($urandom_range(0, 65535));
`endif
            tick(1);
        end
        LD_Row = 1'b0;
        reset = 1'b0;
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
